// File: rtl/pid_controller_mc_pkg.sv
// rtl/pid_controller_mc_pkg.sv - shared types and helpers for the multi-channel PID controller
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_P = 3'd1,
    S_MUL_I = 3'd2,
    S_MUL_D = 3'd3,
    S_SUM   = 3'd4,
    S_OUT   = 3'd5
  } pid_state_t;

  // Accumulator width: full product plus two guard bits for the three-term sum.
  function automatic int acc_width(input int err_w, input int gain_w);
    return err_w + gain_w + 10;
  endfunction

  // Signed saturation on a common 64-bit carrier.
  function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                               input logic signed [63:0] lo,
                                               input logic signed [63:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pid_controller_mc_if.sv
// rtl/pid_controller_mc_if.sv - sample/command bus between error stage, controller and actuator stage
interface pid_controller_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int ERR_W  = 32,
  parameter int GAIN_W = 16,
  parameter int OUT_W  = 16
);
  logic                     err_valid;
  logic                     err_ready;
  logic [CH_W-1:0]          err_ch;
  logic signed [ERR_W-1:0]  err;
  logic signed [GAIN_W-1:0] kp;
  logic signed [GAIN_W-1:0] ki;
  logic signed [GAIN_W-1:0] kd;
  logic [NUM_CH-1:0]        clr;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  out;
  logic                     out_sat;

  modport master (
    output err_valid, err_ch, err, kp, ki, kd, clr,
    input  err_ready, out_valid, out_ch, out, out_sat
  );

  modport slave (
    input  err_valid, err_ch, err, kp, ki, kd, clr,
    output err_ready, out_valid, out_ch, out, out_sat
  );
endinterface

// File: rtl/pid_controller_mc_mul.sv
// rtl/pid_controller_mc_mul.sv - registered signed multiplier shared by all PID terms
module pid_mul #(
  parameter int A_W = 16,
  parameter int B_W = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [A_W-1:0]    a_i,
  input  logic signed [B_W-1:0]    b_i,
  output logic signed [A_W+B_W-1:0] p_o
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] p_q;

  // One product per cycle, available the cycle after the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= P_W'(a_i) * P_W'(b_i);
  end

  assign p_o = p_q;
endmodule

// File: rtl/pid_controller_mc.sv
// rtl/pid_controller_mc.sv - time-shared multi-channel PID controller with anti-windup
module pid_controller_mc
  import pid_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ERR_W   = 32,
  parameter int GAIN_W  = 16,
  parameter int SHIFT   = 10,
  parameter int OUT_W   = 16,
  parameter int OUT_MIN = -5,
  parameter int OUT_MAX = 5,
  parameter int I_LIM   = 2**20
) (
  input logic                clk,
  input logic                rst_n,
  pid_controller_mc_if.slave bus
);
  localparam int IW    = ERR_W + 8;
  localparam int PW    = GAIN_W + IW;
  localparam int ACC_W = acc_width(ERR_W, GAIN_W);

  pid_state_t state_q, state_d;

  logic [CH_W-1:0]          ch_q;
  logic                     ch_ok_q;
  logic signed [ERR_W-1:0]  err_q;
  logic signed [GAIN_W-1:0] kp_q, ki_q, kd_q;
  logic signed [IW-1:0]     icand_q, d_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     commit_q;
  logic                     out_valid_q;
  logic [CH_W-1:0]          out_ch_q;
  logic signed [OUT_W-1:0]  out_q;
  logic                     out_sat_q;

  logic signed [IW-1:0]     integ_q [NUM_CH];
  logic signed [ERR_W-1:0]  eprev_q [NUM_CH];
  logic [NUM_CH-1:0]        primed_q;

  logic signed [IW-1:0]     integ_sel;
  logic signed [ERR_W-1:0]  eprev_sel;
  logic                     primed_sel;
  logic signed [IW-1:0]     icand_d, d_d;

  logic signed [GAIN_W-1:0] mul_a;
  logic signed [IW-1:0]     mul_b;
  logic signed [PW-1:0]     mul_p;

  logic signed [ACC_W-1:0]  sum_w, s_w;
  logic signed [63:0]       s64, s_clamp;
  logic                     windup;

  // Tags at or above NUM_CH are still accepted but never touch channel state.
  logic [(1<<CH_W)-1:0]     ch_ok_map;
  for (genvar g = 0; g < (1 << CH_W); g++) begin : g_ch_ok
    assign ch_ok_map[g] = (g < NUM_CH);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Fixed six-step sequence; a sample is only taken in IDLE
  always_comb begin
    state_d       = state_q;
    bus.err_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.err_ready = 1'b1;
        if (bus.err_valid) state_d = S_MUL_P;
      end
      S_MUL_P: state_d = S_MUL_I;
      S_MUL_I: state_d = S_MUL_D;
      S_MUL_D: state_d = S_SUM;
      S_SUM:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Look up the offered channel's state and form the clamped integral and derivative
  always_comb begin
    integ_sel  = '0;
    eprev_sel  = '0;
    primed_sel = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == bus.err_ch) begin
        integ_sel  = integ_q[k];
        eprev_sel  = eprev_q[k];
        primed_sel = primed_q[k];
      end
    end
    icand_d = IW'(clamp(64'(integ_sel) + 64'(bus.err), -64'(I_LIM), 64'(I_LIM)));
    d_d     = primed_sel ? IW'(64'(bus.err) - 64'(eprev_sel)) : '0;
  end

  // Steer the shared multiplier to one term per MUL state
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_P: begin mul_a = kp_q; mul_b = IW'(err_q); end
      S_MUL_I: begin mul_a = ki_q; mul_b = icand_q;    end
      S_MUL_D: begin mul_a = kd_q; mul_b = d_q;        end
      default: ;
    endcase
  end

  pid_mul #(.A_W(GAIN_W), .B_W(IW)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (mul_p)
  );

  // Final sum, floor scaling, output saturation and the windup inhibit decision
  always_comb begin
    sum_w   = acc_q + ACC_W'(mul_p);
    s_w     = sum_w >>> SHIFT;
    s64     = 64'(s_w);
    s_clamp = clamp(s64, 64'(OUT_MIN), 64'(OUT_MAX));
    windup  = ((s64 > 64'(OUT_MAX)) && !err_q[ERR_W-1] && (err_q != '0)) ||
              ((s64 < 64'(OUT_MIN)) &&  err_q[ERR_W-1]);
  end

  // Sample capture, product accumulation and command register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      err_q       <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      icand_q     <= '0;
      d_q         <= '0;
      acc_q       <= '0;
      commit_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_q       <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.err_valid) begin
            ch_q    <= bus.err_ch;
            ch_ok_q <= ch_ok_map[bus.err_ch];
            err_q   <= bus.err;
            kp_q    <= bus.kp;
            ki_q    <= bus.ki;
            kd_q    <= bus.kd;
            icand_q <= icand_d;
            d_q     <= d_d;
          end
        end
        S_MUL_I: acc_q <= ACC_W'(mul_p);
        S_MUL_D: acc_q <= acc_q + ACC_W'(mul_p);
        S_SUM: begin
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          if (ch_ok_q) begin
            out_q     <= OUT_W'(s_clamp);
            out_sat_q <= (s64 != s_clamp);
            commit_q  <= !windup;
          end else begin
            out_q     <= '0;
            out_sat_q <= 1'b0;
            commit_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel state: clear has priority over the OUT-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        integ_q[k] <= '0;
        eprev_q[k] <= '0;
      end
      primed_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.clr[k]) begin
          integ_q[k]  <= '0;
          eprev_q[k]  <= '0;
          primed_q[k] <= 1'b0;
        end else if (state_q == S_OUT && ch_ok_q && ch_q == CH_W'(k)) begin
          eprev_q[k]  <= err_q;
          primed_q[k] <= 1'b1;
          if (commit_q) integ_q[k] <= icand_q;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out       = out_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_pid_controller_mc.sv
// tb/tb_pid_controller_mc.sv - self-checking bench for the multi-channel PID controller
module tb_pid_controller_mc;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int ERR_W   = 32;
  localparam int GAIN_W  = 16;
  localparam int SHIFT   = 10;
  localparam int OUT_W   = 16;
  localparam int OUT_MIN = -5;
  localparam int OUT_MAX = 5;
  localparam int I_LIM   = 1 << 20;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  pid_controller_mc_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ERR_W(ERR_W),
                         .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();

  pid_controller_mc #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .ERR_W(ERR_W), .GAIN_W(GAIN_W), .SHIFT(SHIFT),
    .OUT_W(OUT_W), .OUT_MIN(OUT_MIN), .OUT_MAX(OUT_MAX), .I_LIM(I_LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel integrator, previous error and primed flag
  longint m_integ [NUM_CH];
  longint m_eprev [NUM_CH];
  bit     m_primed[NUM_CH];

  typedef struct {
    longint o;
    longint sat;
  } mres_t;

  typedef struct {
    int     ch;
    longint err;
    longint kp;
    longint ki;
    longint kd;
    int     clr_pre;
    int     clr_out;
    longint exp_out;
    longint exp_sat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_integ[k]  = 0;
      m_eprev[k]  = 0;
      m_primed[k] = 0;
    end
  endfunction

  function automatic void model_clear(input int mask);
    for (int k = 0; k < NUM_CH; k++) begin
      if (mask[k]) begin
        m_integ[k]  = 0;
        m_eprev[k]  = 0;
        m_primed[k] = 0;
      end
    end
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic mres_t model_step(input int ch, input longint e,
                                       input longint kp, input longint ki, input longint kd);
    mres_t  r;
    longint ic, d, sum, s;
    ic = m_integ[ch] + e;
    if (ic > I_LIM)  ic = I_LIM;
    if (ic < -I_LIM) ic = -I_LIM;
    d   = m_primed[ch] ? e - m_eprev[ch] : 0;
    sum = kp * e + ki * ic + kd * d;
    s   = floor_div(sum, longint'(1) << SHIFT);
    r.o = (s > OUT_MAX) ? OUT_MAX : (s < OUT_MIN) ? OUT_MIN : s;
    r.sat = (r.o != s) ? 1 : 0;
    if (!((s > OUT_MAX && e > 0) || (s < OUT_MIN && e < 0))) m_integ[ch] = ic;
    m_eprev[ch]  = e;
    m_primed[ch] = 1;
    return r;
  endfunction

  task automatic pulse_clr(input int mask);
    bus.clr = NUM_CH'(mask);
    @(negedge clk);
    bus.clr = '0;
    model_clear(mask);
  endtask

  // Starts and ends on a falling edge with the block idle
  task automatic run_sample(input int ch, input longint e, input longint kp, input longint ki,
                            input longint kd, input int clr_out, input longint exp_out,
                            input longint exp_sat, input string tag);
    int guard;
    int lat;
    bit busy_bad;
    guard = 0;
    while (!bus.err_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.err_ch    = CH_W'(ch);
    bus.err       = ERR_W'(e);
    bus.kp        = GAIN_W'(kp);
    bus.ki        = GAIN_W'(ki);
    bus.kd        = GAIN_W'(kd);
    bus.err_valid = 1'b1;
    @(negedge clk);
    bus.err_valid = 1'b0;
    lat      = -1;
    busy_bad = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      if (bus.err_ready) busy_bad = 1'b1;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_ready_busy"}, busy_bad, 0);
    check({tag, "_out"}, bus.out, exp_out);
    check({tag, "_sat"}, bus.out_sat, exp_sat);
    check({tag, "_ch"}, bus.out_ch, ch);
    if (clr_out != 0) bus.clr = NUM_CH'(clr_out);
    @(negedge clk);
    bus.clr = '0;
    check({tag, "_ready_back"}, bus.err_ready, 1);
    check({tag, "_pulse_one"}, bus.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mres_t r;
    int    acc_cnt, pulse_cnt, last_pulse;
    bit    saw;
    int    ch;
    longint e, kp, ki, kd;

    n_cmp  = 0;
    n_fail = 0;
    model_reset();

    //        ch  err            kp ki    kd    pre out  exp sat
    tbl.push_back('{0, 1024,          3, 0,    0,    0,  0,   3, 0});
    tbl.push_back('{0, 4096,          3, 0,    0,    1,  0,   5, 1});
    tbl.push_back('{0, -1,            1, 0,    0,    1,  0,  -1, 0});
    tbl.push_back('{1, 512,           0, 1,    0,    2,  0,   0, 0});
    tbl.push_back('{1, 512,           0, 1,    0,    0,  0,   1, 0});
    tbl.push_back('{2, 512,           0, 1,    0,    4,  0,   0, 0});
    tbl.push_back('{3, 100,           0, 0,    1024, 8,  0,   0, 0});
    tbl.push_back('{3, 103,           0, 0,    1024, 0,  0,   3, 0});
    tbl.push_back('{3, 103,           0, 0,    1024, 8,  0,   0, 0});
    tbl.push_back('{0, 10,            0, 1024, 0,    1,  0,   5, 1});
    tbl.push_back('{0, -3,            0, 1024, 0,    0,  0,  -3, 0});
    tbl.push_back('{0, 0,             0, 1024, 0,    0,  0,  -3, 0});
    tbl.push_back('{2, 2097152,       0, 0,    0,    4,  0,   0, 0});
    tbl.push_back('{2, -1048576+3072, 0, 1,    0,    0,  0,   3, 0});
    tbl.push_back('{1, 2048,          0, 1,    0,    2, 10,   2, 0});
    tbl.push_back('{1, 1024,          0, 1,    0,    0,  0,   1, 0});
    tbl.push_back('{3, 50,            0, 0,    1024, 0,  0,   0, 0});

    rst_n         = 1'b0;
    bus.err_valid = 1'b0;
    bus.err_ch    = '0;
    bus.err       = '0;
    bus.kp        = '0;
    bus.ki        = '0;
    bus.kd        = '0;
    bus.clr       = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ready", bus.err_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_sat", bus.out_sat, 0);

    foreach (tbl[i]) begin
      if (tbl[i].clr_pre != 0) pulse_clr(tbl[i].clr_pre);
      void'(model_step(tbl[i].ch, tbl[i].err, tbl[i].kp, tbl[i].ki, tbl[i].kd));
      run_sample(tbl[i].ch, tbl[i].err, tbl[i].kp, tbl[i].ki, tbl[i].kd, tbl[i].clr_out,
                 tbl[i].exp_out, tbl[i].exp_sat, $sformatf("vec%0d", i));
      model_clear(tbl[i].clr_out);
    end

    // Continuous err_valid: only one accept per six cycles
    bus.err_ch = '0;
    bus.err    = '0;
    bus.kp     = '0;
    bus.ki     = '0;
    bus.kd     = '0;
    acc_cnt    = 0;
    pulse_cnt  = 0;
    last_pulse = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.err_valid = (cyc < 24);
      if (bus.err_valid && bus.err_ready) begin
        acc_cnt++;
        void'(model_step(0, 0, 0, 0, 0));
      end
      if (bus.out_valid) begin
        pulse_cnt++;
        last_pulse = cyc;
      end
      @(negedge clk);
    end
    bus.err_valid = 1'b0;
    check("hold_accepts", acc_cnt, 4);
    check("hold_pulses", pulse_cnt, 4);
    check("hold_last_pulse", last_pulse, 23);

    // Put a non-zero command on the outputs before the reset abort
    r = model_step(3, 4096, 3, 0, 0);
    run_sample(3, 4096, 3, 0, 0, 0, r.o, r.sat, "pre_rst");

    // Reset while in MUL_I
    bus.err_ch    = 2'd2;
    bus.err       = 5000;
    bus.kp        = '0;
    bus.ki        = 16'sd1;
    bus.kd        = '0;
    bus.err_valid = 1'b1;
    @(negedge clk);
    bus.err_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    saw   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    rst_n = 1'b1;
    model_reset();
    check("abort_ready", bus.err_ready, 1);
    check("abort_out", bus.out, 0);
    check("abort_out_ch", bus.out_ch, 0);
    check("abort_out_sat", bus.out_sat, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    check("abort_no_pulse", saw, 0);
    for (int k = 0; k < NUM_CH; k++) begin
      r = model_step(k, 2, 0, 1024, 1024);
      run_sample(k, 2, 0, 1024, 1024, 0, r.o, r.sat, $sformatf("post_rst_ch%0d", k));
    end

    // Randomized samples against the reference model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_clr(int'($urandom_range(1, 15)));
      ch = int'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 9) == 0) e = longint'($urandom_range(0, 4194304)) - 2097152;
      else                           e = longint'($urandom_range(0, 6000)) - 3000;
      kp = longint'($urandom_range(0, 200)) - 100;
      ki = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(0, 200)) - 100;
      kd = longint'($urandom_range(0, 200)) - 100;
      r  = model_step(ch, e, kp, ki, kd);
      run_sample(ch, e, kp, ki, kd, 0, r.o, r.sat, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
